// File: rtl/boruss_pkg.sv
// Shared definitions for the Boruss ALU.
//   DEFAULT_DATA_WIDTH : default operand/result width
//   OP_*               : 8-bit opcode encodings, 0x00-0x0F
//   alu_flags_t        : zero/carry/negative flag bundle
package boruss_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;

   localparam logic [7:0] OP_ADD = 8'h00;
   localparam logic [7:0] OP_SUB = 8'h01;
   localparam logic [7:0] OP_AND = 8'h02;
   localparam logic [7:0] OP_OR  = 8'h03;
   localparam logic [7:0] OP_XOR = 8'h04;
   localparam logic [7:0] OP_NOT = 8'h05;
   localparam logic [7:0] OP_SHL = 8'h06;
   localparam logic [7:0] OP_SHR = 8'h07;
   localparam logic [7:0] OP_JMP = 8'h08;
   localparam logic [7:0] OP_JZ  = 8'h09;
   localparam logic [7:0] OP_JNZ = 8'h0A;
   localparam logic [7:0] OP_JC  = 8'h0B;
   localparam logic [7:0] OP_JNC = 8'h0C;
   localparam logic [7:0] OP_JN  = 8'h0D;
   localparam logic [7:0] OP_JNN = 8'h0E;
   localparam logic [7:0] OP_CMP = 8'h0F;

   typedef struct packed {
      logic zero;
      logic carry;
      logic negative;
   } alu_flags_t;

endpackage

// File: rtl/boruss_alu_core.sv
// Combinational ALU datapath: opcode decode, result and flag generation.
// Ports:
//   operand_a, operand_b : operands (operand_b doubles as jump address)
//   operation_code       : 8-bit opcode
//   result               : computed result
//   flags                : zero/carry/negative derived from result
module boruss_alu_core
   import boruss_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic [7:0]            operation_code,
   output logic [DATA_WIDTH-1:0] result,
   output alu_flags_t            flags
);

   logic [DATA_WIDTH-1:0] r;
   logic                  c;

   always_comb begin
      r = '0;
      c = 1'b0;
      case (operation_code)
         OP_ADD: {c, r} = {1'b0, operand_a} + {1'b0, operand_b};
         // CMP is a subtract whose write-back the control unit may suppress
         OP_SUB, OP_CMP: begin
            r = operand_a - operand_b;
            c = (operand_a < operand_b);
         end
         OP_AND: r = operand_a & operand_b;
         OP_OR:  r = operand_a | operand_b;
         OP_XOR: r = operand_a ^ operand_b;
         OP_NOT: r = ~operand_a;
         OP_SHL: begin
            r = {operand_a[DATA_WIDTH-2:0], 1'b0};
            c = operand_a[DATA_WIDTH-1];
         end
         OP_SHR: begin
            r = {1'b0, operand_a[DATA_WIDTH-1:1]};
            c = operand_a[0];
         end
         // Jump condition is resolved by the control unit; only pass the target
         OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC, OP_JN, OP_JNN: r = operand_b;
         default: begin
            r = '0;
            c = 1'b0;
         end
      endcase
   end

   always_comb begin
      result         = r;
      flags.zero     = (r == '0);
      flags.carry    = c;
      flags.negative = r[DATA_WIDTH-1];
   end

endmodule

// File: rtl/boruss_alu.sv
// Registered Boruss ALU: captures the core output when op_valid is high.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   op_valid        : capture the operation this cycle
//   operand_a/b     : operands, operation_code : opcode
//   result          : registered result
//   zero/carry/negative_flag : registered flags
//   result_valid    : one-cycle pulse when outputs were updated
module boruss_alu
   import boruss_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  op_valid,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic [7:0]            operation_code,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  zero_flag,
   output logic                  carry_flag,
   output logic                  negative_flag,
   output logic                  result_valid
);

   logic [DATA_WIDTH-1:0] core_result;
   alu_flags_t            core_flags;

   boruss_alu_core #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_core (
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .operation_code(operation_code),
      .result        (core_result),
      .flags         (core_flags)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         result        <= '0;
         zero_flag     <= 1'b0;
         carry_flag    <= 1'b0;
         negative_flag <= 1'b0;
         result_valid  <= 1'b0;
      end else begin
         result_valid <= op_valid;
         // Outputs hold while idle
         if (op_valid) begin
            result        <= core_result;
            zero_flag     <= core_flags.zero;
            carry_flag    <= core_flags.carry;
            negative_flag <= core_flags.negative;
         end
      end
   end

endmodule

// File: tb/tb_boruss_alu.sv
// Scoreboard bench for boruss_alu: stimulus pushes expected {result,Z,C,N}
// tagged with the cycle it must appear in; a monitor pops and compares.
module tb_boruss_alu;

   logic       clk = 1'b0;
   logic       rst;
   logic       op_valid;
   logic [7:0] operand_a;
   logic [7:0] operand_b;
   logic [7:0] operation_code;
   logic [7:0] result;
   logic       zero_flag;
   logic       carry_flag;
   logic       negative_flag;
   logic       result_valid;

   boruss_alu #(
      .DATA_WIDTH(8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .op_valid      (op_valid),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .operation_code(operation_code),
      .result        (result),
      .zero_flag     (zero_flag),
      .carry_flag    (carry_flag),
      .negative_flag (negative_flag),
      .result_valid  (result_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [10:0] exp;  // {result, Z, C, N}
      string       name;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got r=%h zcn=%b, expected r=%h zcn=%b",
                  name, act[10:3], act[2:0], exp[10:3], exp[2:0]);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Monitor: every cycle, result_valid must match the scoreboard head.
   always begin
      @(posedge clk);
      #1;
      if (mon_en) begin
         if (sb.size() != 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk1({e.name, " valid"}, result_valid, 1'b1);
            chk(e.name, {result, zero_flag, carry_flag, negative_flag}, e.exp);
         end else if (result_valid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL spurious_valid: got result_valid=%b at cycle %0d, expected 0",
                     result_valid, cyc);
         end
      end
   end

   // Drive one op at the negedge; it is captured at the next posedge.
   task automatic issue(input string name, input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] r, input logic z,
                        input logic c, input logic n);
      exp_t e;
      @(negedge clk);
      op_valid       = 1'b1;
      operation_code = op;
      operand_a      = a;
      operand_b      = b;
      e.cyc  = cyc + 1;
      e.exp  = {r, z, c, n};
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         op_valid       = 1'b0;
         operand_a      = 8'($urandom);
         operand_b      = 8'($urandom);
         operation_code = 8'($urandom);
      end
   endtask

   initial begin
      rst            = 1'b1;
      op_valid       = 1'b0;
      operand_a      = 8'h00;
      operand_b      = 8'h00;
      operation_code = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      chk("reset_state", {result, zero_flag, carry_flag, negative_flag}, 11'h000);
      chk1("reset_valid", result_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      idle(3);
      @(posedge clk);
      #1;
      chk("idle_after_reset", {result, zero_flag, carry_flag, negative_flag}, 11'h000);

      // Arithmetic
      issue("add_10_5",    8'h00, 8'd10,  8'd5,  8'd15,  1'b0, 1'b0, 1'b0);
      issue("add_255_1",   8'h00, 8'd255, 8'd1,  8'h00,  1'b1, 1'b1, 1'b0);
      issue("sub_5_5",     8'h01, 8'd5,   8'd5,  8'd0,   1'b1, 1'b0, 1'b0);
      issue("sub_5_10",    8'h01, 8'd5,   8'd10, 8'd251, 1'b0, 1'b1, 1'b1);
      issue("cmp_15_10",   8'h0F, 8'd15,  8'd10, 8'd5,   1'b0, 1'b0, 1'b0);
      issue("cmp_5_15",    8'h0F, 8'd5,   8'd15, 8'd246, 1'b0, 1'b1, 1'b1);
      // Hold check: last op left 0xF6, Z0 C1 N1
      idle(3);
      @(posedge clk);
      #1;
      chk("idle_hold", {result, zero_flag, carry_flag, negative_flag}, {8'hF6, 3'b011});

      // Logic / shift
      issue("and",         8'h02, 8'hF0, 8'hAA, 8'hA0, 1'b0, 1'b0, 1'b1);
      issue("or",          8'h03, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1);
      issue("xor",         8'h04, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0);
      issue("not",         8'h05, 8'hAA, 8'h13, 8'h55, 1'b0, 1'b0, 1'b0);
      issue("shl_80",      8'h06, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      issue("shr_01",      8'h07, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      issue("shl_55",      8'h06, 8'h55, 8'h00, 8'hAA, 1'b0, 1'b0, 1'b1);
      issue("shr_81",      8'h07, 8'h81, 8'h00, 8'h40, 1'b0, 1'b1, 1'b0);

      // Jumps: pass operand_b, carry always 0
      issue("jmp_40",      8'h08, 8'hFF, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0);
      issue("jmp_00",      8'h08, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      issue("jnc_80",      8'h0C, 8'hFF, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
      issue("jz_ff",       8'h09, 8'h01, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
      issue("jc_01",       8'h0B, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
      issue("jnn_7f",      8'h0E, 8'h80, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0);

      // Undefined opcodes
      issue("undef_10",    8'h10, 8'd42, 8'd24, 8'h00, 1'b1, 1'b0, 1'b0);
      issue("undef_ff",    8'hFF, 8'd42, 8'd24, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(1);

      // Back-to-back
      issue("b2b_add",     8'h00, 8'd10, 8'd5, 8'd15, 1'b0, 1'b0, 1'b0);
      issue("b2b_sub",     8'h01, 8'd10, 8'd5, 8'd5,  1'b0, 1'b0, 1'b0);

      // Reset priority over op_valid
      @(negedge clk);
      rst            = 1'b1;
      op_valid       = 1'b1;
      operation_code = 8'h00;
      operand_a      = 8'd10;
      operand_b      = 8'd5;
      @(posedge clk);
      #1;
      chk("rst_priority", {result, zero_flag, carry_flag, negative_flag}, 11'h000);
      chk1("rst_priority_valid", result_valid, 1'b0);
      @(negedge clk);
      rst      = 1'b0;
      op_valid = 1'b0;

      idle(3);
      @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/boruss_alu.md
Name: boruss_alu

Overview:
Registered 8-bit ALU for the Boruss CPU datapath. It performs arithmetic, logic, single-bit shift, jump-target pass-through and compare operations, selected by an 8-bit opcode. It produces a result plus zero, carry and negative flags. The control unit consumes the result and flags for register write-back, flag-register update and PC load.

Parameters:
- DATA_WIDTH, 8, operand/result width; opcode values are fixed at 8 bits regardless.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  operands/opcode valid this cycle; captures the operation
- operand_a  in  DATA_WIDTH  first operand
- operand_b  in  DATA_WIDTH  second operand / jump address
- operation_code  in  8  opcode
- result  out  DATA_WIDTH  registered result
- zero_flag  out  1  registered; 1 when result == 0
- carry_flag  out  1  registered carry/borrow/shifted-out bit
- negative_flag  out  1  registered; equals result MSB
- result_valid  out  1  one-cycle pulse, outputs updated

Behaviour:
- Reset (rst=1 at rising clk):
  - result=0; zero_flag, carry_flag, negative_flag, result_valid all 0.
  - rst has priority over op_valid.
- Latency:
  - op_valid=1 at edge N → result, flags and result_valid=1 are visible after edge N.
  - One operation per cycle, back-to-back allowed, no stall.
- op_valid=0 at an edge: result and flags hold their previous values; result_valid=0.
- Combinational function, with r = computed result:
  - 0x00 ADD: r = a+b modulo 2^W; C = carry out of MSB.
  - 0x01 SUB: r = a−b modulo 2^W; C = borrow (a<b unsigned).
  - 0x02 AND: r = a&b; C=0.
  - 0x03 OR: r = a|b; C=0.
  - 0x04 XOR: r = a^b; C=0.
  - 0x05 NOT: r = ~a, b ignored; C=0.
  - 0x06 SHL: r = a<<1, LSB filled 0; C = a[MSB].
  - 0x07 SHR: r = a>>1 logical, MSB filled 0; C = a[0].
  - 0x08 JMP, 0x09 JZ, 0x0A JNZ, 0x0B JC, 0x0C JNC, 0x0D JN, 0x0E JNN: r = b (jump address, unconditional pass-through; the condition is evaluated by the control unit); C=0.
  - 0x0F CMP: r = a−b; C = borrow, identical to SUB. The result is still output; the control unit decides whether to write it back.
  - Any other opcode (0x10–0xFF): r = 0; C=0.
- Flag rules for every opcode, including jumps and undefined opcodes: Z = (r==0); N = r[MSB].
  - Undefined opcode therefore gives r=0, Z=1, C=0, N=0.
- Flags are purely a function of the current operation; there is no dependency on the previous flag state.
- Operand/opcode changes while op_valid=0 have no effect on the outputs.

Decomposition:
- Shared package boruss_pkg:
  - DATA_WIDTH default.
  - Opcode localparams OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC, OP_JN, OP_JNN, OP_CMP (0x00–0x0F).
  - A flags struct {zero, carry, negative}.
- One natural sub-module, boruss_alu_core:
  - Purely combinational opcode decode, datapath and flag generation.
  - boruss_alu wraps it with the output register stage, op_valid capture and reset.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → result=0x00, Z=C=N=0, result_valid=0. Then op_valid=0 with random operands → outputs unchanged.
- Arithmetic, one cycle after each op_valid:
  - ADD 10+5 → 15, Z0 C0 N0
  - ADD 255+1 → 0x00, Z1 C1 N0
  - SUB 5−5 → 0, Z1 C0 N0
  - SUB 5−10 → 251, Z0 C1 N1
  - CMP 15−10 → 5, flags 000
  - CMP 5−15 → 246, Z0 C1 N1
- Logic/shift:
  - AND 0xF0&0xAA → 0xA0, N1
  - OR 0xF0|0x0F → 0xFF, N1
  - XOR 0xAA^0xAA → 0, Z1
  - NOT 0xAA → 0x55
  - SHL 0x80 → 0x00, Z1 C1
  - SHR 0x01 → 0x00, Z1 C1
  - SHL 0x55 → 0xAA, N1 C0
- Jumps:
  - JMP b=0x40 → 0x40, flags 000
  - JMP b=0x00 → 0, Z1
  - JNC b=0x80 → 0x80, N1 C0
  - JZ b=0xFF → 0xFF, N1
- Undefined opcodes 0x10 and 0xFF with a=42, b=24 → result 0, Z1 C0 N0.
- Back-to-back and reset priority:
  - ADD 10+5 then SUB 10−5 on consecutive cycles → results 15 then 5 on consecutive cycles, result_valid high both cycles.
  - Assert rst in the same cycle as op_valid → outputs 0, result_valid=0.
